// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply
// and restoring unsigned divide, with valid/ready handshakes on both sides.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_GT   = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH:0]          sum;
  logic [SHW-1:0]          shamt;

  logic [WIDTH-1:0] sc_y;
  logic             sc_carry;
  logic             sc_ovf;
  logic             sc_err;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] sa_nx;
  logic [WIDTH-1:0] sb_nx;
  logic [WIDTH-1:0] fin_y;
  logic             multi;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  assign a_s   = a;
  assign b_s   = b;
  assign sum   = {1'b0, a} + {1'b0, b};
  assign shamt = b[SHW-1:0];
  assign multi = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);

  always_comb begin
    sc_y     = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_err   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_y     = sum[WIDTH-1:0];
        sc_carry = sum[WIDTH];
        sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_y     = a - b;
        sc_carry = (a >= b);
        sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  sc_y = ~a;
      OP_AND:  sc_y = a & b;
      OP_OR:   sc_y = a | b;
      OP_XOR:  sc_y = a ^ b;
      OP_GT:   sc_y = {{(WIDTH-1){1'b0}}, (a_s > b_s)};
      OP_EQ:   sc_y = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_SLL:  sc_y = a << shamt;
      OP_SRL:  sc_y = a >> shamt;
      OP_SRA:  sc_y = a_s >>> shamt;
      OP_MUL, OP_DIVU, OP_REMU: sc_y = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // Shared iteration registers: MUL uses acc=partial product, sa=multiplicand,
  // sb=multiplier; DIVU/REMU use acc=remainder, sa=dividend/quotient, sb=divisor.
  assign rem_sh = {acc, sa[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, sb});

  always_comb begin
    acc_nx = acc;
    sa_nx  = sa;
    sb_nx  = sb;
    if (op_r == OP_MUL) begin
      acc_nx = acc + (sb[0] ? sa : '0);
      sa_nx  = sa << 1;
      sb_nx  = sb >> 1;
    end else begin
      // A successful trial subtraction always leaves a remainder below the divisor.
      acc_nx = ge ? (rem_sh[WIDTH-1:0] - sb) : rem_sh[WIDTH-1:0];
      sa_nx  = {sa[WIDTH-2:0], ge};
    end
    fin_y = (op_r == OP_DIVU) ? sa_nx : acc_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= '0;
      acc   <= '0;
      sa    <= '0;
      sb    <= '0;
      y     <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (multi) begin
              op_r  <= op;
              cnt   <= '0;
              acc   <= '0;
              sa    <= a;
              sb    <= b;
              state <= BUSY;
            end else begin
              y     <= sc_y;
              zero  <= (sc_y == '0);
              carry <= sc_carry;
              ovf   <= sc_ovf;
              err   <= sc_err;
              state <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= acc_nx;
          sa  <= sa_nx;
          sb  <= sb_nx;
          if (cnt == LAST) begin
            y     <= fin_y;
            zero  <= (fin_y == '0);
            carry <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed checks of seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       carry;
  logic       ovf;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .zero(zero), .carry(carry), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the 8-bit operands.
  task automatic model(input int o, input int av, input int bv,
                       output logic [7:0] ey, output logic [3:0] ef);
    int sa, sb, r, amt;
    bit c, v, e;
    sa = (av > 127) ? av - 256 : av;
    sb = (bv > 127) ? bv - 256 : bv;
    amt = bv % 8;
    c = 0; v = 0; e = 0;
    case (o)
      0: begin r = av + bv; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      1: begin r = av - bv; c = (av >= bv); v = (sa - sb > 127) || (sa - sb < -128); end
      2: r = ~av;
      3: r = av & bv;
      4: r = av | bv;
      5: r = av ^ bv;
      6: r = (sa > sb) ? 1 : 0;
      7: r = (av == bv) ? 1 : 0;
      8: r = av << amt;
      9: r = av >> amt;
      10: r = sa >>> amt;
      11: r = av * bv;
      12: r = (bv == 0) ? 255 : av / bv;
      13: r = (bv == 0) ? av : av % bv;
      default: begin r = 0; e = 1; end
    endcase
    ey = r[7:0];
    ef = {e, v, c, (ey == 8'h00)};
  endtask

  task automatic do_op(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] ey;
    logic [3:0] ef;
    int lat, exp_lat;
    bit busy_rdy;
    model(int'(o), int'(av), int'(bv), ey, ef);
    exp_lat = (o == 4'd11 || o == 4'd12 || o == 4'd13) ? 9 : 1;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 1;
    busy_rdy = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_rdy = 1;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("ready_while_busy", busy_rdy, 0);
    chk($sformatf("y op=%0d a=%0h b=%0h", o, av, bv), y, ey);
    chk($sformatf("flags op=%0d a=%0h b=%0h", o, av, bv), {err, ovf, carry, zero}, ef);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("ready_after_handoff", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", {err, ovf, carry, zero}, 4'b0000);
    rst = 1'b0;

    // Directed vectors from the plan
    do_op(4'd0, 8'h7F, 8'h01);
    do_op(4'd0, 8'hFF, 8'h01);
    do_op(4'd1, 8'd5, 8'd7);
    do_op(4'd6, 8'hFD, 8'h02);
    do_op(4'd7, 8'h5A, 8'h5A);
    do_op(4'd10, 8'h90, 8'h0B);
    do_op(4'd11, 8'd13, 8'd11);
    do_op(4'd12, 8'd100, 8'd7);
    do_op(4'd13, 8'd100, 8'd7);
    do_op(4'd12, 8'd42, 8'd0);
    do_op(4'd13, 8'd42, 8'd0);
    do_op(4'd15, 8'h12, 8'h34);
    do_op(4'd14, 8'h00, 8'h00);

    // Backpressure: result held while out_ready stays low
    @(negedge clk);
    in_valid = 1'b1; op = 4'd0; a = 8'd10; b = 8'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_y", y, 8'd30);
      chk("bp_flags", {err, ovf, carry, zero}, 4'b0000);
      chk("bp_in_ready", in_ready, 0);
      in_valid = 1'b1; op = 4'd1; a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    chk("bp_y_final", y, 8'd30);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);

    // Reset three cycles into a multiply
    in_valid = 1'b1; op = 4'd11; a = 8'd13; b = 8'd11;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_y", y, 0);
    chk("mrst_flags", {err, ovf, carry, zero}, 4'b0000);
    chk("mrst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle_ready", in_ready, 1);
    chk("mrst_no_valid", out_valid, 0);
    do_op(4'd0, 8'd2, 8'd3);

    // Randomized operations, with zero divisors mixed in
    for (int i = 0; i < 60; i++) begin
      logic [3:0] ro;
      logic [7:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_op(ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
